// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch block: FSM state encoding and error causes.
package instr_fetch_pkg;

   typedef enum logic [2:0] {
      FETCH_IDLE  = 3'd0,
      FETCH_REQ   = 3'd1,
      FETCH_WAIT  = 3'd2,
      FETCH_HOLD  = 3'd3,
      FETCH_DRAIN = 3'd4
   } fetch_state_t;

   localparam logic [1:0] FETCH_ERR_NONE     = 2'd0;
   localparam logic [1:0] FETCH_ERR_MISALIGN = 2'd1;
   localparam logic [1:0] FETCH_ERR_TIMEOUT  = 2'd2;

   // Instruction words are 4-byte aligned; any low address bit set is a fault.
   function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
      return addr_lsbs != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_watchdog.sv
// Saturating wait counter: cleared while a request is being offered, counts while a
// response is outstanding, flags the cycle in which the limit is reached (or later).
module instr_fetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // ">=" rather than "==" so a saturated count still expires a later drain.
   assign o_expire = i_en && (r_count >= (LIMIT - 1'b1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one memory read per fetch request, holds the word for the
// decoder and pulses o_fetch_done on acceptance (drives the PC update).
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [ADDR_WIDTH-1:0] i_pc_in,
   input  logic                  i_fetch_req,
   input  logic                  i_flush,
   output logic                  o_mem_req_valid,
   input  logic                  i_mem_req_ready,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
   output logic                  o_instr_valid,
   input  logic                  i_instr_ready,
   output logic [DATA_WIDTH-1:0] o_instr_out,
   output logic [ADDR_WIDTH-1:0] o_instr_pc,
   output logic                  o_fetch_done,
   output logic                  o_fetch_err,
   output logic                  o_busy,
   output logic [1:0]            o_err_cause,
   output fetch_state_t          o_state
);

   // Handshakes: a transfer happens on a cycle where valid and ready are both high;
   // valid never depends on ready, and payload is held stable while valid && !ready.
   // The memory response is valid-only: a single-cycle pulse with no back-pressure.

   fetch_state_t          r_state;
   fetch_state_t          w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0] r_instr_pc;
   logic                  r_done;
   logic [1:0]            r_err_code;
   logic                  w_latch;
   logic                  w_capture;
   logic                  w_done_nxt;
   logic [1:0]            w_err_nxt;
   logic                  w_wd_clr;
   logic                  w_wd_en;
   logic                  w_expire;

   assign w_wd_clr = (r_state == FETCH_REQ);
   assign w_wd_en  = (r_state == FETCH_WAIT) || (r_state == FETCH_DRAIN);

   instr_fetch_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (w_wd_clr),
      .i_en     (w_wd_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= FETCH_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_capture   = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = FETCH_ERR_NONE;
      case (r_state)
         FETCH_IDLE: begin
            if (i_fetch_req && !i_flush) begin
               w_latch = 1'b1;
               if (is_misaligned(i_pc_in[1:0])) w_err_nxt   = FETCH_ERR_MISALIGN;
               else                             w_state_nxt = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            // An accepted request still owes a response, so a flush must drain it.
            if (i_flush)              w_state_nxt = i_mem_req_ready ? FETCH_DRAIN : FETCH_IDLE;
            else if (i_mem_req_ready) w_state_nxt = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (i_flush) begin
               w_state_nxt = FETCH_DRAIN;
            end else if (i_mem_rsp_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = FETCH_HOLD;
            end else if (w_expire) begin
               w_err_nxt   = FETCH_ERR_TIMEOUT;
               w_state_nxt = FETCH_IDLE;
            end
         end
         FETCH_HOLD: begin
            if (i_flush) begin
               w_state_nxt = FETCH_IDLE;
            end else if (i_instr_ready) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = FETCH_IDLE;
            end
         end
         FETCH_DRAIN: begin
            if (i_mem_rsp_valid || w_expire) w_state_nxt = FETCH_IDLE;
         end
         default: w_state_nxt = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr     <= '0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_done     <= 1'b0;
         r_err_code <= FETCH_ERR_NONE;
      end else begin
         r_done     <= w_done_nxt;
         r_err_code <= w_err_nxt;
         if (w_latch) r_addr <= i_pc_in;
         if (w_capture) begin
            r_instr    <= i_mem_rsp_data;
            r_instr_pc <= r_addr;
         end
      end
   end

   assign o_mem_req_valid = (r_state == FETCH_REQ);
   assign o_mem_addr      = r_addr;
   assign o_instr_valid   = (r_state == FETCH_HOLD);
   assign o_instr_out     = r_instr;
   assign o_instr_pc      = r_instr_pc;
   assign o_fetch_done    = r_done;
   assign o_fetch_err     = (r_err_code != FETCH_ERR_NONE);
   assign o_err_cause     = r_err_code;
   assign o_busy          = (r_state != FETCH_IDLE);
   assign o_state         = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          clk;
   logic          rst;
   logic [AW-1:0] pc_in;
   logic          fetch_req;
   logic          flush;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_rsp_valid;
   logic [DW-1:0] mem_rsp_data;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic          fetch_done;
   logic          fetch_err;
   logic          busy;
   logic [1:0]    err_cause;
   fetch_state_t  state;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   // Model: which phase of the single outstanding fetch we are in, as plain flags.
   bit          m_req, m_wait, m_drain, m_hold, m_done, m_err;
   logic [1:0]  m_cause;
   int          m_cnt;
   logic [31:0] m_addr, m_instr, m_ipc;

   instr_fetch #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_pc_in         (pc_in),
      .i_fetch_req     (fetch_req),
      .i_flush         (flush),
      .o_mem_req_valid (mem_req_valid),
      .i_mem_req_ready (mem_req_ready),
      .o_mem_addr      (mem_addr),
      .i_mem_rsp_valid (mem_rsp_valid),
      .i_mem_rsp_data  (mem_rsp_data),
      .o_instr_valid   (instr_valid),
      .i_instr_ready   (instr_ready),
      .o_instr_out     (instr_out),
      .o_instr_pc      (instr_pc),
      .o_fetch_done    (fetch_done),
      .o_fetch_err     (fetch_err),
      .o_busy          (busy),
      .o_err_cause     (err_cause),
      .o_state         (state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_in();
      fetch_req     = 1'b0;
      flush         = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      instr_ready   = 1'b0;
      pc_in         = '0;
   endtask

   // ---------------- reference model (advances on each rising edge) ----------------
   initial forever begin
      @(posedge clk);
      m_done  = 0;
      m_err   = 0;
      m_cause = FETCH_ERR_NONE;
      if (rst) begin
         {m_req, m_wait, m_drain, m_hold} = '0;
         m_cnt   = 0;
         m_addr  = '0;
         m_instr = '0;
         m_ipc   = '0;
      end else if (!(m_req || m_wait || m_drain || m_hold)) begin
         if (fetch_req && !flush) begin
            m_addr = pc_in;
            if ((pc_in % 4) != 0) begin
               m_err   = 1;
               m_cause = FETCH_ERR_MISALIGN;
            end else begin
               m_req = 1;
            end
         end
      end else if (m_req) begin
         if (mem_req_ready) begin
            m_req = 0;
            m_cnt = 0;
            if (flush) m_drain = 1;
            else       m_wait  = 1;
         end else if (flush) begin
            m_req = 0;
         end
      end else if (m_wait) begin
         m_cnt++;
         m_wait = 0;
         if (flush) begin
            m_drain = 1;
         end else if (mem_rsp_valid) begin
            m_hold  = 1;
            m_instr = mem_rsp_data;
            m_ipc   = m_addr;
         end else if (m_cnt >= TO) begin
            m_err   = 1;
            m_cause = FETCH_ERR_TIMEOUT;
         end else begin
            m_wait = 1;
         end
      end else if (m_drain) begin
         m_cnt++;
         if (mem_rsp_valid || m_cnt >= TO) m_drain = 0;
      end else if (m_hold) begin
         if (flush) begin
            m_hold = 0;
         end else if (instr_ready) begin
            m_hold = 0;
            m_done = 1;
         end
      end
   end

   // ---------------- scoreboard compare, every cycle away from the edge ----------------
   task automatic compare();
      bit busy_e;
      busy_e = m_req || m_wait || m_drain || m_hold;
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_req));
      if (m_req) chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", 32'(instr_valid), 32'(m_hold));
      if (m_hold) begin
         chk("instr_out", instr_out, m_instr);
         chk("instr_pc", instr_pc, m_ipc);
      end
      chk("fetch_done", 32'(fetch_done), 32'(m_done));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      if (m_err) chk("err_cause", 32'(err_cause), 32'(m_cause));
      chk("busy", 32'(busy), 32'(busy_e));
      chk("state_idle", 32'(state == FETCH_IDLE), 32'(!busy_e));
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) compare();
   end

   // ---------------- stimulus ----------------
   task automatic to_hold(input logic [31:0] pc, input logic [31:0] d);
      idle_in();
      pc_in = pc; fetch_req = 1'b1; mem_req_ready = 1'b1;
      step(); fetch_req = 1'b0;
      step(); mem_rsp_valid = 1'b1; mem_rsp_data = d;
      step(); mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
      chk("hold_valid", 32'(instr_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      repeat (2) step();
      chk_en = 1;
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Basic fetch: request N, valid N+1, response N+2, instr N+3, done N+4.
      pc_in = 32'h10; fetch_req = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1;
      step(); fetch_req = 1'b0;
      chk("t1_req_valid", 32'(mem_req_valid), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h10);
      step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0050_0093;
      step(); mem_rsp_valid = 1'b0;
      chk("t1_instr_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr_out", instr_out, 32'h0050_0093);
      chk("t1_instr_pc", instr_pc, 32'h10);
      step();
      chk("t1_fetch_done", 32'(fetch_done), 32'd1);

      // Back-pressure on both sides.
      idle_in(); pc_in = 32'h40; fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); fetch_req = 1'b0;
         chk("t2_req_valid", 32'(mem_req_valid), 32'd1);
         chk("t2_mem_addr", mem_addr, 32'h40);
      end
      mem_req_ready = 1'b1;
      step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
      step(); mem_rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_hold_valid", 32'(instr_valid), 32'd1);
         chk("t2_hold_out", instr_out, 32'h1234_5678);
         chk("t2_no_done", 32'(fetch_done), 32'd0);
      end
      instr_ready = 1'b1;
      step(); instr_ready = 1'b0;
      chk("t2_done", 32'(fetch_done), 32'd1);
      step();
      chk("t2_single_done", 32'(fetch_done), 32'd0);

      // Misaligned address.
      idle_in(); pc_in = 32'h6; fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      chk("t3_err", 32'(fetch_err), 32'd1);
      chk("t3_cause", 32'(err_cause), 32'(FETCH_ERR_MISALIGN));
      chk("t3_no_req", 32'(mem_req_valid), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      step();
      chk("t3_err_pulse", 32'(fetch_err), 32'd0);

      // Timeout after TO wait cycles; late response ignored.
      idle_in(); pc_in = 32'h80; fetch_req = 1'b1; mem_req_ready = 1'b1;
      step(); fetch_req = 1'b0;
      for (int i = 0; i < TO; i++) begin
         step();
         chk("t4_waiting", 32'(busy), 32'd1);
         chk("t4_no_err", 32'(fetch_err), 32'd0);
      end
      step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
      chk("t4_err", 32'(fetch_err), 32'd1);
      chk("t4_cause", 32'(err_cause), 32'(FETCH_ERR_TIMEOUT));
      chk("t4_idle", 32'(busy), 32'd0);
      step(); mem_rsp_valid = 1'b0;
      chk("t4_late_ignored", 32'(instr_valid), 32'd0);

      // Flush while waiting; the drained response is never delivered.
      idle_in(); pc_in = 32'h100; fetch_req = 1'b1; mem_req_ready = 1'b1;
      step(); fetch_req = 1'b0;
      step(); flush = 1'b1;
      step(); flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
      chk("t5_draining", 32'(busy), 32'd1);
      step(); mem_rsp_valid = 1'b0;
      chk("t5_no_valid", 32'(instr_valid), 32'd0);
      chk("t5_no_err", 32'(fetch_err), 32'd0);
      pc_in = 32'h20; fetch_req = 1'b1; instr_ready = 1'b1;
      step(); fetch_req = 1'b0;
      chk("t5_addr2", mem_addr, 32'h20);
      step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0020;
      step(); mem_rsp_valid = 1'b0;
      chk("t5_instr_out", instr_out, 32'hCAFE_0020);
      chk("t5_instr_pc", instr_pc, 32'h20);
      step();
      chk("t5_done", 32'(fetch_done), 32'd1);

      // Reset while holding an instruction, then a late response.
      to_hold(32'h200, 32'h1111_2222);
      rst = 1'b1;
      step(); rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_6666;
      chk("t6a_valid", 32'(instr_valid), 32'd0);
      chk("t6a_instr_out", instr_out, 32'd0);
      chk("t6a_instr_pc", instr_pc, 32'd0);
      chk("t6a_mem_addr", mem_addr, 32'd0);
      chk("t6a_busy", 32'(busy), 32'd0);
      step(); mem_rsp_valid = 1'b0;
      chk("t6a_late_ignored", 32'(instr_valid), 32'd0);

      // Flush and decoder accept in the same hold cycle: flush wins.
      to_hold(32'h300, 32'h3333_4444);
      flush = 1'b1; instr_ready = 1'b1;
      step(); flush = 1'b0; instr_ready = 1'b0;
      chk("t6b_no_done", 32'(fetch_done), 32'd0);
      chk("t6b_valid", 32'(instr_valid), 32'd0);
      chk("t6b_busy", 32'(busy), 32'd0);

      // Randomized traffic, checked only by the per-cycle model compare.
      for (int c = 0; c < 4000; c++) begin
         step();
         rst           = ($urandom_range(0, 299) == 0);
         fetch_req     = ($urandom_range(0, 2) == 0);
         pc_in         = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
         flush         = ($urandom_range(0, 11) == 0);
         mem_req_ready = 1'($urandom_range(0, 1));
         mem_rsp_valid = ($urandom_range(0, 3) == 0);
         mem_rsp_data  = $urandom();
         instr_ready   = 1'($urandom_range(0, 1));
      end
      step(); idle_in(); rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumes the address produced by the program counter (pc_current) and fetches the instruction word from instruction memory.
- Uses a valid/ready request channel and a valid-only response channel toward memory.
- Presents the fetched word to the decoder through a valid/ready handshake.
- Emits a one-cycle fetch_done pulse when the decoder accepts the instruction; this drives program_counter.update_pc. The block therefore closes the PC → memory → decode loop from the reader side.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before the fetch is aborted (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_WIDTH  fetch address (program_counter.pc_current).
- fetch_req  in  1  start a fetch of pc_in; sampled only in IDLE.
- flush  in  1  abandon the current fetch (redirect or trap).
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_WIDTH  request address, word aligned.
- mem_rsp_valid  in  1  read data valid, single-cycle pulse.
- mem_rsp_data  in  DATA_WIDTH  read data.
- instr_valid  out  1  instruction available to the decoder.
- instr_ready  in  1  decoder accepts the instruction.
- instr_out  out  DATA_WIDTH  fetched instruction.
- instr_pc  out  ADDR_WIDTH  address of instr_out.
- fetch_done  out  1  one-cycle pulse on decoder acceptance; drives update_pc.
- fetch_err  out  1  one-cycle pulse on misaligned pc_in or timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - Every output is 0, including mem_addr, instr_out and instr_pc.
  - The timeout counter is 0.
  - Reset mid-operation discards everything. A response arriving after reset is ignored because the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - If fetch_req=1 and flush=0, latch pc_in into addr_q.
  - If pc_in[1:0] != 0: fetch_err=1 on the next cycle and stay in IDLE; no memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1 and mem_addr=addr_q, both registered.
  - When mem_req_ready=1, go to WAIT and clear the counter.
  - Address must stay stable while valid and not ready.
- WAIT:
  - The counter increments each cycle.
  - On mem_rsp_valid=1: capture instr_out=mem_rsp_data and instr_pc=addr_q, then go to HOLD.
  - If the counter reaches TIMEOUT_CYCLES without a response: pulse fetch_err, go to IDLE.
  - A response on the same cycle as the limit wins; the counter does not pulse an error.
- HOLD:
  - instr_valid=1; instr_out and instr_pc are held stable.
  - On instr_ready=1: pulse fetch_done next cycle, go to IDLE.
- Flush handling (flush has highest priority):
  - IDLE: no effect, and fetch_req is ignored that cycle.
  - REQ with mem_req_ready=0: withdraw valid, go to IDLE.
  - REQ with mem_req_ready=1, or WAIT: go to DRAIN. DRAIN swallows the one outstanding response (or the timeout), then goes to IDLE with no fetch_err.
  - HOLD: drop instr_valid, go to IDLE, no fetch_done even if instr_ready=1 on the same cycle.
- fetch_req outside IDLE is ignored. Only one request is outstanding at a time.
- mem_rsp_valid in IDLE, REQ or HOLD is spurious and ignored.
- Minimum latency from a fetch_req in cycle N:
  - mem_req_valid in N+1.
  - With ready in N+1 and response in N+2, instr_valid in N+3.
  - fetch_done in N+4 if instr_ready is already high.
- Width rules:
  - The counter is wide enough for TIMEOUT_CYCLES and saturates; it does not wrap.
  - Addresses pass through unmodified; no arithmetic is done on the PC.

Decomposition:
- defines.v gains:
  - FETCH_IDLE/REQ/WAIT/HOLD/DRAIN state encodings (3 bits).
  - FETCH_ERR_MISALIGN/TIMEOUT constants.
- One sub-module: fetch_watchdog, a clear/enable saturating counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Basic fetch:
   - Stimulus: pc_in=0x00000010, fetch_req pulse; memory ready immediately; rsp_data=0x00500093 one cycle later; instr_ready=1.
   - Response: mem_addr=0x10, instr_valid at N+3 with instr_out=0x00500093 and instr_pc=0x10, fetch_done pulse at N+4.
2. Backpressure:
   - Stimulus: mem_req_ready low for 3 cycles; instr_ready low for 4 cycles.
   - Response: mem_req_valid and mem_addr stable throughout; instr_out stable; exactly one fetch_done.
3. Misaligned:
   - Stimulus: pc_in=0x00000006, fetch_req.
   - Response: fetch_err pulse next cycle, mem_req_valid never asserted, busy stays 0.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=4, request accepted, no response.
   - Response: fetch_err after 4 WAIT cycles, state back to IDLE. A late response is ignored: instr_valid stays 0.
5. Flush in WAIT:
   - Stimulus: flush asserted the cycle after acceptance; response 0xDEADBEEF follows; then a new fetch_req with pc_in=0x20.
   - Response: no instr_valid for 0xDEADBEEF; the second fetch delivers data for address 0x20.
6. Reset mid-HOLD and simultaneous events:
   - Stimulus (a): rst while instr_valid=1. Response: all outputs 0 next cycle.
   - Stimulus (b): flush and instr_ready both high in HOLD. Response: no fetch_done.
